interp_coord_align_buffer: RTL and testbench

- Parametrised successor to the fractional-coordinate buffer in the rotation datapath.
- Stores per-pixel fractional coordinates (fx, fy) in an internal dual-pointer RAM FIFO while the frame-buffer fetch fetches the neighbour pixels.
- Re-aligns the coordinates with the returned NTAP neighbour taps so the bilinear interpolator sees a coherent {fx, fy, taps, valid} word.
- Adds occupancy, almost-full back-pressure, sticky overflow/underflow flags and a frame-sync flush.

---
 rtl/interp_coord_align_buffer.sv | 109 ++++++++++
 tb/tb_interp_coord_align_buffer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/interp_coord_align_buffer.sv
// Fractional-coordinate FIFO that re-aligns (fx, fy) with the neighbour taps
// returned by the frame-buffer fetch, feeding a coherent word to the interpolator.
module interp_coord_align_buffer #(
  parameter int FX_W     = 11,
  parameter int FY_W     = 11,
  parameter int PIX_W    = 16,
  parameter int NTAP     = 4,
  parameter int ADDR_W   = 11,
  parameter int AF_LEVEL = 2040,
  parameter int TAP_DLY  = 1
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_fsyn,
  input  logic                    i_wr_en,
  input  logic [FX_W-1:0]         iv_fx,
  input  logic [FY_W-1:0]         iv_fy,
  input  logic                    i_rd_en,
  input  logic [NTAP*PIX_W-1:0]   iv_taps,
  output logic                    o_valid,
  output logic [FX_W-1:0]         ov_fx,
  output logic [FY_W-1:0]         ov_fy,
  output logic [NTAP*PIX_W-1:0]   ov_taps,
  output logic [ADDR_W:0]         ov_level,
  output logic                    o_empty,
  output logic                    o_full,
  output logic                    o_almost_full,
  output logic                    o_overflow,
  output logic                    o_underflow
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam int DW    = FX_W + FY_W;
  localparam int TW    = NTAP * PIX_W;
  localparam logic [ADDR_W:0]   FULL_LVL = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   AF_LVL   = (ADDR_W+1)'(AF_LEVEL);
  localparam logic [ADDR_W:0]   LVL_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

  logic [DW-1:0]     mem [DEPTH];
  logic [DW-1:0]     rd_data;
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0]   level;
  logic              wa, ra;
  logic [TAP_DLY-1:0][TW-1:0] tap_pipe;

  // Status flags come only from the registered level.
  assign o_empty       = (level == '0);
  assign o_full        = (level == FULL_LVL);
  assign o_almost_full = (level >= AF_LVL);
  assign ov_level      = level;

  // A read that frees a slot lets a write into a full FIFO; no fall-through when empty.
  assign ra = i_rd_en & ~o_empty;
  assign wa = i_wr_en & (~o_full | ra);

  always_ff @(posedge i_clk) begin
    if (wa && !i_fsyn) mem[wr_ptr] <= {iv_fx, iv_fy};
  end

  // Registered RAM read port doubles as the held output word.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)               rd_data <= '0;
    else if (ra && !i_fsyn)    rd_data <= mem[rd_ptr];
  end

  assign ov_fx = rd_data[DW-1:FY_W];
  assign ov_fy = rd_data[FY_W-1:0];

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level       <= '0;
      o_valid     <= 1'b0;
      o_overflow  <= 1'b0;
      o_underflow <= 1'b0;
    end else if (i_fsyn) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level       <= '0;
      o_valid     <= 1'b0;
      o_overflow  <= 1'b0;
      o_underflow <= 1'b0;
    end else begin
      if (wa) wr_ptr <= wr_ptr + PTR_ONE;
      if (ra) rd_ptr <= rd_ptr + PTR_ONE;
      case ({wa, ra})
        2'b10:   level <= level + LVL_ONE;
        2'b01:   level <= level - LVL_ONE;
        default: level <= level;
      endcase
      o_valid <= ra;
      if (i_wr_en && !wa) o_overflow  <= 1'b1;
      if (i_rd_en && !ra) o_underflow <= 1'b1;
    end
  end

  // Tap chain free-runs and is deliberately untouched by frame sync.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      tap_pipe <= '0;
    end else begin
      tap_pipe[0] <= iv_taps;
      for (int i = 1; i < TAP_DLY; i++) tap_pipe[i] <= tap_pipe[i-1];
    end
  end

  assign ov_taps = tap_pipe[TAP_DLY-1];
endmodule

// File: tb/tb_interp_coord_align_buffer.sv
// Bench: directed table, fill/wrap sequences and random traffic against a queue model;
// a second instance with TAP_DLY=3 runs on the same stimulus.
module tb_interp_coord_align_buffer;
  localparam int DEPTH = 2048;
  localparam int AFL   = 2040;

  logic        clk = 1'b0, rst = 1'b1, fsyn = 1'b0, wr_en = 1'b0, rd_en = 1'b0;
  logic [10:0] in_fx = '0, in_fy = '0;
  logic [63:0] in_taps = '0;

  logic v1, emp1, ful1, af1, ovf1, unf1;
  logic [10:0] fx1, fy1;
  logic [63:0] taps1;
  logic [11:0] lvl1;
  logic v3, emp3, ful3, af3, ovf3, unf3;
  logic [10:0] fx3, fy3;
  logic [63:0] taps3;
  logic [11:0] lvl3;

  interp_coord_align_buffer dut1 (
    .i_clk(clk), .i_reset(rst), .i_fsyn(fsyn), .i_wr_en(wr_en), .iv_fx(in_fx), .iv_fy(in_fy),
    .i_rd_en(rd_en), .iv_taps(in_taps), .o_valid(v1), .ov_fx(fx1), .ov_fy(fy1), .ov_taps(taps1),
    .ov_level(lvl1), .o_empty(emp1), .o_full(ful1), .o_almost_full(af1),
    .o_overflow(ovf1), .o_underflow(unf1));

  interp_coord_align_buffer #(.TAP_DLY(3)) dut3 (
    .i_clk(clk), .i_reset(rst), .i_fsyn(fsyn), .i_wr_en(wr_en), .iv_fx(in_fx), .iv_fy(in_fy),
    .i_rd_en(rd_en), .iv_taps(in_taps), .o_valid(v3), .ov_fx(fx3), .ov_fy(fy3), .ov_taps(taps3),
    .ov_level(lvl3), .o_empty(emp3), .o_full(ful3), .o_almost_full(af3),
    .o_overflow(ovf3), .o_underflow(unf3));

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int tot_cnt  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Reference model: a queue of {fx,fy} words plus tap history.
  logic [21:0] mq[$];
  logic [10:0] mfx, mfy;
  logic        mv, movf, munf;
  logic [63:0] h[3];

  task automatic model_reset();
    mq.delete();
    mfx = '0; mfy = '0; mv = 1'b0; movf = 1'b0; munf = 1'b0;
    for (int i = 0; i < 3; i++) h[i] = '0;
  endtask

  task automatic model_step(input logic w, input logic r, input logic f,
                            input logic [10:0] x, input logic [10:0] y, input logic [63:0] t);
    bit can_rd, can_wr;
    h[2] = h[1]; h[1] = h[0]; h[0] = t;
    if (f) begin
      mq.delete(); movf = 1'b0; munf = 1'b0; mv = 1'b0;
    end else begin
      can_rd = (mq.size() > 0);
      can_wr = (mq.size() < DEPTH) || (r && can_rd);
      mv = 1'b0;
      if (r && can_rd) begin {mfx, mfy} = mq.pop_front(); mv = 1'b1; end
      else if (r) munf = 1'b1;
      if (w && can_wr) mq.push_back({x, y});
      else if (w) movf = 1'b1;
    end
  endtask

  task automatic check_all(input string tag);
    int n;
    n = mq.size();
    chk({tag, " valid"},  64'(v1),   64'(mv));
    chk({tag, " fx"},     64'(fx1),  64'(mfx));
    chk({tag, " fy"},     64'(fy1),  64'(mfy));
    chk({tag, " level"},  64'(lvl1), 64'(n));
    chk({tag, " empty"},  64'(emp1), 64'(n == 0));
    chk({tag, " full"},   64'(ful1), 64'(n == DEPTH));
    chk({tag, " afull"},  64'(af1),  64'(n >= AFL));
    chk({tag, " ovf"},    64'(ovf1), 64'(movf));
    chk({tag, " unf"},    64'(unf1), 64'(munf));
    chk({tag, " taps"},   taps1,     h[0]);
    chk({tag, " d3 valid"}, 64'(v3),  64'(mv));
    chk({tag, " d3 fx"},  64'(fx3),  64'(mfx));
    chk({tag, " d3 fy"},  64'(fy3),  64'(mfy));
    chk({tag, " d3 level"}, 64'(lvl3), 64'(n));
    chk({tag, " d3 flags"}, 64'({emp3, ful3, af3, ovf3, unf3}),
        64'({n == 0, n == DEPTH, n >= AFL, movf, munf}));
    chk({tag, " d3 taps"}, taps3, h[2]);
  endtask

  task automatic cyc(input logic w, input logic r, input logic f, input logic [10:0] x,
                     input logic [10:0] y, input logic [63:0] t, input string tag);
    wr_en = w; rd_en = r; fsyn = f; in_fx = x; in_fy = y; in_taps = t;
    @(posedge clk); #1;
    model_step(w, r, f, x, y, t);
    check_all(tag);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, " valid"}, 64'({v1, v3}), 64'(0));
    chk({tag, " fxfy"},  64'({fx1, fy1, fx3, fy3}), 64'(0));
    chk({tag, " taps1"}, taps1, 64'(0));
    chk({tag, " taps3"}, taps3, 64'(0));
    chk({tag, " level"}, 64'({lvl1, lvl3}), 64'(0));
    chk({tag, " flags"}, 64'({emp1, ful1, af1, ovf1, unf1, emp3, ful3, af3, ovf3, unf3}),
        64'(10'b10000_10000));
  endtask

  typedef struct {
    logic w, r, f;
    logic [10:0] x, y;
    logic [63:0] t;
    logic ev;
    logic [10:0] efx, efy;
    int   elvl;
    logic eunf;
  } vec_t;

  function automatic vec_t mk(input logic w, input logic r, input logic f, input logic [10:0] x,
                              input logic [10:0] y, input logic [63:0] t, input logic ev,
                              input logic [10:0] efx, input logic [10:0] efy, input int elvl,
                              input logic eunf);
    vec_t v;
    v.w = w; v.r = r; v.f = f; v.x = x; v.y = y; v.t = t;
    v.ev = ev; v.efx = efx; v.efy = efy; v.elvl = elvl; v.eunf = eunf;
    return v;
  endfunction

  vec_t tbl[10];
  logic [63:0] rt;
  logic [10:0] efx;

  initial begin
    tbl[0] = mk(1'b1, 1'b0, 1'b0, 11'd5, 11'd7, 64'h0, 1'b0, 11'd0, 11'd0, 1, 1'b0);
    tbl[1] = mk(1'b1, 1'b0, 1'b0, 11'd6, 11'd8, 64'h0, 1'b0, 11'd0, 11'd0, 2, 1'b0);
    tbl[2] = mk(1'b1, 1'b0, 1'b0, 11'd7, 11'd9, 64'h0, 1'b0, 11'd0, 11'd0, 3, 1'b0);
    tbl[3] = mk(1'b0, 1'b1, 1'b0, 11'd0, 11'd0, 64'h0004_0003_0002_0001, 1'b1, 11'd5, 11'd7, 2, 1'b0);
    tbl[4] = mk(1'b0, 1'b1, 1'b0, 11'd0, 11'd0, 64'h0014_0013_0012_0011, 1'b1, 11'd6, 11'd8, 1, 1'b0);
    tbl[5] = mk(1'b0, 1'b1, 1'b0, 11'd0, 11'd0, 64'h0024_0023_0022_0021, 1'b1, 11'd7, 11'd9, 0, 1'b0);
    tbl[6] = mk(1'b0, 1'b0, 1'b0, 11'd0, 11'd0, 64'h0, 1'b0, 11'd7, 11'd9, 0, 1'b0);
    tbl[7] = mk(1'b1, 1'b1, 1'b0, 11'd3, 11'd4, 64'h0, 1'b0, 11'd7, 11'd9, 1, 1'b1);
    tbl[8] = mk(1'b0, 1'b1, 1'b0, 11'd0, 11'd0, 64'h0, 1'b1, 11'd3, 11'd4, 0, 1'b1);
    tbl[9] = mk(1'b1, 1'b0, 1'b1, 11'd1, 11'd1, 64'h0, 1'b0, 11'd3, 11'd4, 0, 1'b0);

    model_reset();
    #12;
    check_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // Directed table: basic push/pop alignment, empty wr+rd, frame sync with write.
    for (int i = 0; i < 10; i++) begin
      cyc(tbl[i].w, tbl[i].r, tbl[i].f, tbl[i].x, tbl[i].y, tbl[i].t, $sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d exp valid", i), 64'(v1), 64'(tbl[i].ev));
      chk($sformatf("tbl%0d exp fxfy", i), 64'({fx1, fy1}), 64'({tbl[i].efx, tbl[i].efy}));
      chk($sformatf("tbl%0d exp level", i), 64'(lvl1), 64'(tbl[i].elvl));
      chk($sformatf("tbl%0d exp unf", i), 64'(unf1), 64'(tbl[i].eunf));
      chk($sformatf("tbl%0d exp taps", i), taps1, tbl[i].t);
    end
    cyc(1'b0, 1'b0, 1'b0, 11'd0, 11'd0, 64'h0, "post_fsyn");
    chk("fsyn write dropped", 64'(lvl1), 64'(0));

    // Fill to full with fx = index.
    for (int i = 0; i < DEPTH; i++) begin
      cyc(1'b1, 1'b0, 1'b0, i[10:0], ~i[10:0], {$urandom, $urandom}, "fill");
      if (i == AFL - 2) chk("afull below level", 64'(af1), 64'(0));
      if (i == AFL - 1) chk("afull at level", 64'(af1), 64'(1));
    end
    chk("full flag", 64'(ful1), 64'(1));
    chk("full level", 64'(lvl1), 64'(DEPTH));
    cyc(1'b1, 1'b0, 1'b0, 11'h7ff, 11'h7ff, 64'h0, "push_full");
    chk("overflow set", 64'(ovf1), 64'(1));
    chk("level after overflow", 64'(lvl1), 64'(DEPTH));
    cyc(1'b1, 1'b1, 1'b0, 11'h5ab, 11'h0ab, 64'h0, "full_wr_rd");
    chk("full wr+rd level", 64'(lvl1), 64'(DEPTH));
    chk("full wr+rd pops 0", 64'(fx1), 64'(0));

    // Drain: order continues 1,2,... then the word written at full appears last.
    for (int i = 0; i < DEPTH; i++) begin
      rt = {$urandom, $urandom};
      cyc(1'b0, 1'b1, 1'b0, 11'd0, 11'd0, rt, "drain");
      efx = (i == DEPTH - 1) ? 11'h5ab : 11'(i + 1);
      if (fx1 !== efx || i == DEPTH - 1) chk($sformatf("drain order %0d", i), 64'(fx1), 64'(efx));
    end
    chk("drained empty", 64'(emp1), 64'(1));

    // Underflow, 10 pushes, then frame sync with write clears everything.
    cyc(1'b0, 1'b1, 1'b0, 11'd0, 11'd0, 64'h0, "underflow");
    chk("underflow set", 64'(unf1), 64'(1));
    for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, 1'b0, 11'(i + 100), 11'(i), 64'h0, "push10");
    cyc(1'b1, 1'b0, 1'b1, 11'h123, 11'h321, 64'h0, "fsyn10");
    chk("fsyn level", 64'(lvl1), 64'(0));
    chk("fsyn flags", 64'({emp1, ovf1, unf1}), 64'(3'b100));

    // Random traffic, several read/write mixes.
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 1000; i++) begin
        cyc(1'($urandom_range(0, 99) < (p == 0 ? 70 : (p == 1 ? 30 : 50))),
            1'($urandom_range(0, 99) < (p == 0 ? 40 : (p == 1 ? 70 : 50))),
            1'($urandom_range(0, 199) == 0),
            11'($urandom), 11'($urandom), {$urandom, $urandom}, $sformatf("rand%0d", p));
      end
    end

    // Short stream, then asynchronous reset in the middle of a cycle.
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 1'b0, 11'(i + 1), 11'(i + 2), 64'h0, "pre_rst");
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0, 11'd0, 11'd0, {$urandom, $urandom}, "pre_rst_rd");
    chk("d3 taps delay", taps3, h[2]);
    #2 rst = 1'b1;
    #1 check_zero("async reset");
    model_reset();
    @(posedge clk); #1;
    check_zero("held reset");
    rst = 1'b0;
    cyc(1'b1, 1'b0, 1'b0, 11'd9, 11'd9, 64'hdead_beef_0000_0001, "post_rst");
    chk("post reset level", 64'(lvl1), 64'(1));

    wr_en = 1'b0; rd_en = 1'b0; fsyn = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end
endmodule
